// File: rtl/axil_split2_if.sv
// axil_split2_if: AXI-lite bundle of all five channels, shared by the host and both downstream ports
interface axil_split2_if #(parameter int AW = 12, parameter int DW = 32);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_split2.sv
// axil_split2: AXI-lite 1-to-2 router keyed on the top address bit, one read and one write outstanding
module axil_split2 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  axil_split2_if.slave  s,
  axil_split2_if.master m0,
  axil_split2_if.master m1
);
  localparam int AW = ADDR_WIDTH - 1;
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {RIDLE, RADDR, RDATA, RRESP} r_state_t;
  typedef enum logic [1:0] {WCOLLECT, WFWD, WRESP, WBACK} w_state_t;
  r_state_t r_st, r_nxt;
  w_state_t w_st, w_nxt;
  logic                  r_sel, w_sel, aw_full, w_full, aw_pend, w_pend;
  logic [AW-1:0]         r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_data, w_data, m_rdata;
  logic [SW-1:0]         w_strb;
  logic [1:0]            r_resp, b_resp, m_rresp, m_bresp;
  logic                  m_arready, m_rvalid, m_awready, m_wready, m_bvalid, aw_done, w_done;
  assign m_arready = r_sel ? m1.arready : m0.arready;
  assign m_rvalid  = r_sel ? m1.rvalid  : m0.rvalid;
  assign m_rdata   = r_sel ? m1.rdata   : m0.rdata;
  assign m_rresp   = r_sel ? m1.rresp   : m0.rresp;
  assign m_awready = w_sel ? m1.awready : m0.awready;
  assign m_wready  = w_sel ? m1.wready  : m0.wready;
  assign m_bvalid  = w_sel ? m1.bvalid  : m0.bvalid;
  assign m_bresp   = w_sel ? m1.bresp   : m0.bresp;
  assign aw_done   = !aw_pend || m_awready;
  assign w_done    = !w_pend || m_wready;
  always_ff @(posedge clk) begin
    r_st <= rst ? RIDLE : r_nxt;
    w_st <= rst ? WCOLLECT : w_nxt;
  end
  always_comb begin
    r_nxt = r_st;
    unique case (r_st)
      RIDLE:   r_nxt = s.arvalid ? RADDR : RIDLE;
      RADDR:   r_nxt = m_arready ? RDATA : RADDR;
      RDATA:   r_nxt = m_rvalid ? RRESP : RDATA;
      default: r_nxt = s.rready ? RIDLE : RRESP;
    endcase
  end
  always_comb begin
    w_nxt = w_st;
    unique case (w_st)
      WCOLLECT: w_nxt = (aw_full && w_full) ? WFWD : WCOLLECT;
      WFWD:     w_nxt = (aw_done && w_done) ? WRESP : WFWD;
      WRESP:    w_nxt = m_bvalid ? WBACK : WRESP;
      default:  w_nxt = s.bready ? WCOLLECT : WBACK;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp <= '0;
    end else begin
      if (s.arvalid && s.arready) {r_sel, r_addr} <= s.araddr;
      if (r_st == RDATA && m_rvalid) begin
        r_data <= m_rdata;
        r_resp <= m_rresp;
      end
    end
  end
  // Holding registers stay full until the host takes B, which blocks new AW/W
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_resp  <= '0;
    end else begin
      if (s.awvalid && s.awready) begin
        {w_sel, w_addr} <= s.awaddr;
        aw_full <= 1'b1;
      end
      if (s.wvalid && s.wready) begin
        w_data <= s.wdata;
        w_strb <= s.wstrb;
        w_full <= 1'b1;
      end
      if (w_st == WCOLLECT && w_nxt == WFWD) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        aw_pend <= aw_pend && !m_awready;
        w_pend  <= w_pend && !m_wready;
      end
      if (w_st == WRESP && m_bvalid) b_resp <= m_bresp;
      if (s.bvalid && s.bready) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
    end
  end
  assign s.arready  = !rst && r_st == RIDLE;
  assign s.rvalid   = r_st == RRESP;
  assign s.rdata    = r_data;
  assign s.rresp    = r_resp;
  assign s.awready  = !rst && !aw_full;
  assign s.wready   = !rst && !w_full;
  assign s.bvalid   = w_st == WBACK;
  assign s.bresp    = b_resp;
  assign m0.arvalid = r_st == RADDR && !r_sel;
  assign m1.arvalid = r_st == RADDR && r_sel;
  assign m0.rready  = r_st == RDATA && !r_sel;
  assign m1.rready  = r_st == RDATA && r_sel;
  assign m0.araddr  = r_addr;
  assign m1.araddr  = r_addr;
  assign m0.awvalid = w_st == WFWD && aw_pend && !w_sel;
  assign m1.awvalid = w_st == WFWD && aw_pend && w_sel;
  assign m0.wvalid  = w_st == WFWD && w_pend && !w_sel;
  assign m1.wvalid  = w_st == WFWD && w_pend && w_sel;
  assign m0.bready  = w_st == WRESP && !w_sel;
  assign m1.bready  = w_st == WRESP && w_sel;
  assign m0.awaddr  = w_addr;
  assign m1.awaddr  = w_addr;
  assign m0.wdata   = w_data;
  assign m1.wdata   = w_data;
  assign m0.wstrb   = w_strb;
  assign m1.wstrb   = w_strb;
endmodule

// File: tb/tb_axil_split2.sv
// tb_axil_split2: directed scoreboard bench for axil_split2 with delay-configurable downstream models
module tb_axil_split2;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  axil_split2_if #(.AW(12), .DW(32)) s_if ();
  axil_split2_if #(.AW(11), .DW(32)) m_if [2] ();
  axil_split2 #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s(s_if), .m0(m_if[0]), .m1(m_if[1])
  );
  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [10:0] exp_ar[2][$];
  logic [46:0] exp_aw[2][$];
  int          ar_dly[2], r_dly[2], aw_dly[2];
  logic [31:0] rd_data[2];
  logic [1:0]  rd_resp[2], wr_resp[2];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask
  for (genvar k = 0; k < 2; k++) begin : g_dn
    initial begin : rd_model
      logic [10:0] a;
      bit ok;
      m_if[k].arready = 1'b0;
      m_if[k].rvalid  = 1'b0;
      m_if[k].rdata   = '0;
      m_if[k].rresp   = '0;
      forever begin
        @(negedge clk);
        if (rst || !m_if[k].arvalid) continue;
        a = m_if[k].araddr;
        if (exp_ar[k].size() == 0) fail($sformatf("unexpected_ar port%0d addr %h", k, a));
        else chk($sformatf("araddr_m%0d", k), 64'(a), 64'(exp_ar[k].pop_front()));
        ok = 1;
        for (int i = 0; i < ar_dly[k]; i++) begin
          @(negedge clk);
          if (rst) begin ok = 0; break; end
          chk($sformatf("ar_hold_m%0d", k), {m_if[k].arvalid, m_if[k].araddr}, {1'b1, a});
        end
        if (!ok) continue;
        m_if[k].arready = 1'b1;
        @(posedge clk);
        #1 m_if[k].arready = 1'b0;
        for (int i = 0; i < r_dly[k]; i++) begin
          @(negedge clk);
          if (rst) begin ok = 0; break; end
        end
        if (!ok) continue;
        m_if[k].rvalid = 1'b1;
        m_if[k].rdata  = rd_data[k];
        m_if[k].rresp  = rd_resp[k];
        ok = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (rst) break;
          if (m_if[k].rready) begin ok = 1; break; end
        end
        if (ok) begin
          @(posedge clk);
          #1;
        end
        m_if[k].rvalid = 1'b0;
      end
    end
    initial begin : wr_model
      logic [46:0] w;
      bit ok;
      m_if[k].awready = 1'b0;
      m_if[k].wready  = 1'b0;
      m_if[k].bvalid  = 1'b0;
      m_if[k].bresp   = '0;
      forever begin
        @(negedge clk);
        if (rst || !m_if[k].awvalid) continue;
        chk($sformatf("aw_w_together_m%0d", k), 64'(m_if[k].wvalid), 64'd1);
        w = {m_if[k].awaddr, m_if[k].wdata, m_if[k].wstrb};
        if (exp_aw[k].size() == 0) fail($sformatf("unexpected_aw port%0d %h", k, w));
        else chk($sformatf("aw_w_m%0d", k), 64'(w), 64'(exp_aw[k].pop_front()));
        ok = 1;
        for (int i = 0; i < aw_dly[k]; i++) begin
          @(negedge clk);
          if (rst) begin ok = 0; break; end
          chk($sformatf("aw_hold_m%0d", k), 64'(m_if[k].awvalid), 64'd1);
        end
        if (!ok) continue;
        m_if[k].awready = 1'b1;
        m_if[k].wready  = 1'b1;
        @(posedge clk);
        #1;
        m_if[k].awready = 1'b0;
        m_if[k].wready  = 1'b0;
        m_if[k].bvalid  = 1'b1;
        m_if[k].bresp   = wr_resp[k];
        ok = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (rst) break;
          if (m_if[k].bready) begin ok = 1; break; end
        end
        if (ok) begin
          @(posedge clk);
          #1;
        end
        m_if[k].bvalid = 1'b0;
      end
    end
  end
  // Host-side monitor: pops the scoreboard on each R/B handshake and checks R holds while stalled
  initial begin : host_mon
    bit r_hold = 0;
    logic [33:0] r_prev;
    forever begin
      @(negedge clk);
      if (r_hold && !rst) chk("r_hold", {s_if.rvalid, s_if.rdata, s_if.rresp}, {1'b1, r_prev});
      if (!rst && s_if.rvalid && s_if.rready) begin
        if (exp_r.size() == 0) fail("unexpected_r");
        else chk("r_payload", {s_if.rdata, s_if.rresp}, exp_r.pop_front());
      end
      if (!rst && s_if.bvalid && s_if.bready) begin
        if (exp_b.size() == 0) fail("unexpected_b");
        else chk("bresp", 64'(s_if.bresp), 64'(exp_b.pop_front()));
      end
      r_hold = !rst && s_if.rvalid && !s_if.rready;
      r_prev = {s_if.rdata, s_if.rresp};
    end
  end
  task automatic host_ar(input logic [11:0] a);
    int i;
    s_if.arvalid = 1'b1;
    s_if.araddr  = a;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_if.arready) break;
    end
    if (i == 100) fail("timeout_ar");
    @(posedge clk);
    #1 s_if.arvalid = 1'b0;
  endtask
  task automatic host_aw(input logic [11:0] a);
    int i;
    s_if.awvalid = 1'b1;
    s_if.awaddr  = a;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_if.awready) break;
    end
    if (i == 100) fail("timeout_aw");
    @(posedge clk);
    #1 s_if.awvalid = 1'b0;
  endtask
  task automatic host_w(input logic [31:0] d, input logic [3:0] st);
    int i;
    s_if.wvalid = 1'b1;
    s_if.wdata  = d;
    s_if.wstrb  = st;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_if.wready) break;
    end
    if (i == 100) fail("timeout_w");
    @(posedge clk);
    #1 s_if.wvalid = 1'b0;
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_b.size() == 0 && exp_ar[0].size() == 0 && exp_ar[1].size() == 0 &&
          exp_aw[0].size() == 0 && exp_aw[1].size() == 0) break;
    end
    if (i == 300) fail("timeout_wait_done");
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_valids"}, {s_if.rvalid, s_if.bvalid, m_if[0].arvalid, m_if[1].arvalid, m_if[0].awvalid,
        m_if[1].awvalid, m_if[0].wvalid, m_if[1].wvalid}, 8'h00);
    chk({nm, "_readies"}, {s_if.arready, s_if.awready, s_if.wready}, 3'b111);
  endtask
  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    s_if.arvalid = 0; s_if.araddr = '0; s_if.rready = 1;
    s_if.awvalid = 0; s_if.awaddr = '0; s_if.wvalid = 0; s_if.wdata = '0; s_if.wstrb = '0; s_if.bready = 1;
    for (int k = 0; k < 2; k++) begin
      ar_dly[k] = 0; r_dly[k] = 0; aw_dly[k] = 0;
      rd_data[k] = '0; rd_resp[k] = '0; wr_resp[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_resp", {s_if.rresp, s_if.bresp}, 4'h0);
    @(posedge clk);
    #1;
    // simple read routed to m0
    rd_data[0] = 32'hA5A5_0001; rd_resp[0] = 2'b00;
    exp_ar[0].push_back(11'h004);
    exp_r.push_back({32'hA5A5_0001, 2'b00});
    host_ar(12'h004);
    wait_done();
    // slow m1: ARREADY after 3 cycles, R 2 cycles later
    ar_dly[1] = 3; r_dly[1] = 2; rd_data[1] = 32'hDEAD_BEEF; rd_resp[1] = 2'b00;
    exp_ar[1].push_back(11'h008);
    exp_r.push_back({32'hDEAD_BEEF, 2'b00});
    host_ar(12'h808);
    for (int i = 0; i < 50 && exp_r.size() > 0; i++) begin
      @(negedge clk);
      chk("arready_busy", {s_if.arready, m_if[0].arvalid}, 2'b00);
    end
    wait_done();
    ar_dly[1] = 0; r_dly[1] = 0;
    // write with W leading AW by 4 cycles, DECERR from m0
    wr_resp[0] = 2'b11;
    exp_aw[0].push_back({11'h010, 32'h1234_5678, 4'h3});
    exp_b.push_back(2'b11);
    host_w(32'h1234_5678, 4'h3);
    repeat (4) begin
      @(negedge clk);
      chk("wready_held_low", 64'(s_if.wready), 64'd0);
    end
    @(posedge clk);
    #1 host_aw(12'h010);
    for (int i = 0; i < 50 && exp_b.size() > 0; i++) begin
      @(negedge clk);
      chk("wready_until_b", 64'(s_if.wready), 64'd0);
    end
    wait_done();
    chk("wready_after_b", 64'(s_if.wready), 64'd1);
    // back-to-back reads with host R stalled 5 cycles
    rd_data[0] = 32'h1111_1111; rd_resp[0] = 2'b00;
    exp_ar[0].push_back(11'h00C);
    exp_r.push_back({32'h1111_1111, 2'b00});
    exp_ar[0].push_back(11'h014);
    exp_r.push_back({32'h2222_2222, 2'b10});
    s_if.rready = 1'b0;
    host_ar(12'h00C);
    fork host_ar(12'h014); join_none
    for (int i = 0; i < 50 && !s_if.rvalid; i++) @(negedge clk);
    rd_data[0] = 32'h2222_2222; rd_resp[0] = 2'b10;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdata", {s_if.rvalid, s_if.rdata, s_if.rresp, s_if.arready}, {1'b1, 32'h1111_1111, 2'b00, 1'b0});
    end
    @(posedge clk);
    #1 s_if.rready = 1'b1;
    @(negedge clk);
    chk("ar_blocked_at_r_hs", 64'(s_if.arready), 64'd0);
    @(negedge clk);
    chk("ar_open_after_r_hs", 64'(s_if.arready), 64'd1);
    wait_done();
    // concurrent read to m0 and write to m1
    rd_data[0] = 32'h0BAD_F00D; rd_resp[0] = 2'b01; wr_resp[1] = 2'b10;
    exp_ar[0].push_back(11'h000);
    exp_r.push_back({32'h0BAD_F00D, 2'b01});
    exp_aw[1].push_back({11'h000, 32'hCAFE_0005, 4'hF});
    exp_b.push_back(2'b10);
    fork
      host_ar(12'h000);
      host_aw(12'h800);
      host_w(32'hCAFE_0005, 4'hF);
    join
    wait_done();
    // reset while the read waits in RDATA and the write in WFWD
    r_dly[0] = 20; aw_dly[1] = 20; rd_data[0] = 32'h7777_7777;
    exp_ar[0].push_back(11'h030);
    exp_aw[1].push_back({11'h040, 32'h3333_4444, 4'h5});
    fork
      host_ar(12'h030);
      host_aw(12'h840);
      host_w(32'h3333_4444, 4'h5);
    join
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {m_if[0].rready, m_if[1].awvalid, m_if[1].wvalid}, 3'b111);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_r.delete();
    exp_b.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    r_dly[0] = 0; aw_dly[1] = 0; rd_data[0] = 32'h5A5A_5A5A; rd_resp[0] = 2'b00;
    @(posedge clk);
    #1;
    exp_ar[0].push_back(11'h020);
    exp_r.push_back({32'h5A5A_5A5A, 2'b00});
    host_ar(12'h020);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_split2.md
Name: axil_split2

Overview:
- Single-slave to dual-master AXI-lite router. It sits directly upstream of the read-only info block and of a user control-register bank.
- The host-side AXI-lite port is routed by the top address bit: 0 selects port m0 (info block), 1 selects port m1 (control bank).
- At most one outstanding read and one outstanding write. All payload is registered, so no combinational path crosses from the slave side to either master side.
- Read and write paths operate fully independently.

Parameters:
- ADDR_WIDTH, 12, slave address width in bits; must be at least 2.
- DATA_WIDTH, 32, data width in bits; must be 32 or 64.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_axi_AW{VALID in 1, READY out 1, ADDR in ADDR_WIDTH}: slave write address.
- s_axi_W{VALID in 1, READY out 1, DATA in DATA_WIDTH, STRB in DATA_WIDTH/8}: slave write data.
- s_axi_B{VALID out 1, READY in 1, RESP out 2}: slave write response.
- s_axi_AR{VALID in 1, READY out 1, ADDR in ADDR_WIDTH}: slave read address.
- s_axi_R{VALID out 1, READY in 1, DATA out DATA_WIDTH, RESP out 2}: slave read data.
- mK_axi_* for K=0,1: same five channels with directions mirrored; mK ADDR width is ADDR_WIDTH-1.

Behaviour:
- Routing: sel = ADDR[ADDR_WIDTH-1]; forwarded address = ADDR[ADDR_WIDTH-2:0]. WDATA, WSTRB, RDATA and all RESP codes pass through unmodified, including DECERR from downstream.
- Reset: every VALID output, every READY output and every B/R response register is 0 in the cycle after rst is sampled high. Data and address registers are don't-care.
- Reset mid-transaction abandons the transaction; downstream blocks are reset by the same rst.
- Read FSM states: RIDLE → RADDR → RDATA → RRESP → RIDLE.
  - RIDLE: s_ARREADY=1. On AR handshake, capture address and sel, go to RADDR.
  - RADDR: m{sel}_ARVALID=1; the unselected ARVALID stays 0. On m{sel}_ARREADY, go to RDATA.
  - RDATA: m{sel}_RREADY=1. On m{sel}_RVALID, capture RDATA and RRESP, go to RRESP.
  - RRESP: s_RVALID=1, held with stable payload until s_RREADY, then go to RIDLE.
  - s_ARREADY is 0 in every state except RIDLE.
- Read latency with zero-wait downstream and s_RREADY=1:
  - AR handshake in cycle 0; m_ARVALID in cycle 1.
  - If the downstream returns R in the cycle after its AR handshake (cycle 2), s_RVALID asserts in cycle 3.
  - Next s_ARREADY in cycle 4.
- Write address and data capture:
  - AW and W are captured independently into holding registers in any order.
  - s_AWREADY = AW holding register empty; s_WREADY = W holding register empty.
  - Same-cycle AW and W are both captured.
- Write FSM states: WCOLLECT → WFWD → WRESP → WBACK → WCOLLECT.
  - WCOLLECT: when both holding registers are full, go to WFWD.
  - WFWD: m{sel}_AWVALID and m{sel}_WVALID are raised together. Each drops independently on its own handshake. When both are done, go to WRESP.
  - WRESP: m{sel}_BREADY=1. On m{sel}_BVALID, capture BRESP, go to WBACK.
  - WBACK: s_BVALID=1 until s_BREADY. On that handshake, clear both holding registers and go to WCOLLECT.
- No new AW or W is accepted until the current B handshake completes.
- A read and a write may both be in flight at once, including to the same port. No ordering is enforced between the read and write paths.
- The unselected port's VALID and READY outputs are always 0.

Test Plan:
- Read addr 0x004, m0 returns RDATA=0xA5A5_0001, RRESP=0 → s_RDATA=0xA5A5_0001, RRESP=0; m1_ARVALID never asserted; m0_ARADDR=0x004.
- Read addr 0x808 with m1 ARREADY delayed 3 cycles and RVALID 2 further cycles → m1_ARADDR=0x008, held stable while waiting; s_ARREADY low throughout; single s_RVALID pulse.
- Write to 0x010 with W presented 4 cycles before AW, WSTRB=0x3, m0 BRESP=2'b11 → m0_WSTRB=0x3; s_BRESP=2'b11; s_WREADY low from the cycle after W capture until the B handshake.
- Back-to-back reads with s_RREADY held low 5 cycles → RDATA/RRESP stable; second AR not accepted until the cycle after the R handshake.
- Concurrent read of 0x000 and write to 0x800 issued in the same cycle → both complete correctly, each on its own port.
- rst asserted while in RDATA and WFWD → next cycle all VALIDs 0, s_ARREADY=1, s_AWREADY=1, s_WREADY=1; a fresh read then completes normally.
